sal_axi_aw_b_apb_unit: RTL and testbench

//  Write-path front end of the SAL DDR2 controller. Accepts AXI address-channel requests and queues them

---
 rtl/sal_axi_pkg.sv | 25 ++
 rtl/sal_sync_fifo.sv | 72 +++++++
 rtl/sal_axi_aw_b_apb_unit.sv | 203 ++++++++++++++++++++
 tb/tb_sal_axi_aw_b_apb_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : sal_axi_pkg
//  Purpose  : Shared widths, response codes and APB register offsets for the
//             SAL write-path front end.
//  Revision : 1.0
// ============================================================================
package sal_axi_pkg;

    localparam int c_id_w   = 4;
    localparam int c_addr_w = 32;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_SLVERR = 2'b10
    } bresp_t;

    localparam logic [11:0] c_reg_ctrl   = 12'h000;
    localparam logic [11:0] c_reg_status = 12'h004;
    localparam logic [11:0] c_reg_aw_cnt = 12'h008;
    localparam logic [11:0] c_reg_b_cnt  = 12'h00C;
    localparam logic [11:0] c_reg_limit  = 12'h010;

endpackage
`default_nettype wire

// File: rtl/sal_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sal_sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO with level output.
//  Revision : 1.0
// ============================================================================
module sal_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] c_depth = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == c_depth);
    assign level_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push at full is still taken when the head leaves in the same cycle.
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   cnt_d = cnt_q + LVL_W'(1);
            2'b01:   cnt_d = cnt_q - LVL_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/sal_axi_aw_b_apb_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sal_axi_aw_b_apb_unit
//  Purpose  : SAL DDR2 write-path front end: AXI address intake, B response
//             return and APB control/statistics registers.
//  Revision : 1.0
// ============================================================================
module sal_axi_aw_b_apb_unit
    import sal_axi_pkg::*;
#(
    parameter int ID_W      = c_id_w,
    parameter int ADDR_W    = c_addr_w,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [11:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              avalid,
    output logic              aready,
    input  logic [ID_W-1:0]   aid,
    input  logic [ADDR_W-1:0] aaddr,
    input  logic [7:0]        alen,
    input  logic [2:0]        asize,
    input  logic [1:0]        aburst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ID_W-1:0]   req_id,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_len,
    input  logic              done_valid,
    input  logic [ID_W-1:0]   done_id,
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp
);

    localparam int REQ_W  = ID_W + ADDR_W + 8;
    localparam int RSP_W  = ID_W + 2;
    localparam int REQ_LW = $clog2(REQ_DEPTH) + 1;
    localparam int RSP_LW = $clog2(RSP_DEPTH) + 1;

    logic              en_q, en_d;
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       aw_cnt_q, aw_cnt_d;
    logic [31:0]       b_cnt_q, b_cnt_d;

    logic              w_req_full, w_req_empty;
    logic              w_rsp_full, w_rsp_empty;
    logic [REQ_LW-1:0] w_req_level;
    logic [RSP_LW-1:0] w_rsp_level;
    logic [REQ_W-1:0]  w_req_dout;
    logic [RSP_W-1:0]  w_rsp_dout;
    logic [RSP_W-1:0]  w_rsp_din;
    logic              w_in_range;
    logic              w_a_hs;
    logic              w_b_hs;
    logic              w_req_push;
    logic              w_err_push;
    logic              w_rsp_push;
    logic              w_ovf_set;
    logic              w_apb_acc;
    logic              w_apb_wr;
    logic              w_mapped;
    logic              w_apb_err;
    logic [2:0]        w_req_lvl3;
    logic [2:0]        w_rsp_lvl3;
    logic [31:0]       w_status;
    logic              unused_inputs;

    assign unused_inputs = ^{asize, aburst};

    // ------------------------------------------------------------------
    // AXI address intake and response return
    // ------------------------------------------------------------------
    assign w_in_range = (aaddr <= limit_q);

    // An out-of-range request cannot share the response FIFO with a
    // completion in the same cycle, so it is held off instead.
    assign aready = rst_n & en_q & ~w_req_full & ~w_rsp_full
                  & ~(done_valid & ~w_in_range);

    assign w_a_hs     = avalid & aready;
    assign w_req_push = w_a_hs & w_in_range;
    assign w_err_push = w_a_hs & ~w_in_range;
    assign w_rsp_push = done_valid | w_err_push;
    assign w_rsp_din  = done_valid ? {done_id, BRESP_OKAY} : {aid, BRESP_SLVERR};

    assign req_valid = ~w_req_empty;
    assign bvalid    = ~w_rsp_empty;
    assign w_b_hs    = bvalid & bready;
    assign w_ovf_set = done_valid & w_rsp_full & ~w_b_hs;

    assign {req_id, req_addr, req_len} = w_req_dout;
    assign {bid, bresp}                = w_rsp_dout;

    sal_sync_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_req_push),
        .data_i  ({aid, aaddr, alen}),
        .pop_i   (req_ready),
        .data_o  (w_req_dout),
        .full_o  (w_req_full),
        .empty_o (w_req_empty),
        .level_o (w_req_level)
    );

    sal_sync_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_rsp_push),
        .data_i  (w_rsp_din),
        .pop_i   (bready),
        .data_o  (w_rsp_dout),
        .full_o  (w_rsp_full),
        .empty_o (w_rsp_empty),
        .level_o (w_rsp_level)
    );

    // ------------------------------------------------------------------
    // APB register block
    // ------------------------------------------------------------------
    assign pready    = 1'b1;
    assign w_apb_acc = rst_n & psel & penable;
    assign w_apb_wr  = w_apb_acc & pwrite;
    assign w_mapped  = paddr inside {c_reg_ctrl, c_reg_status, c_reg_aw_cnt,
                                     c_reg_b_cnt, c_reg_limit};
    assign w_apb_err = ~w_mapped
                     | (pwrite & ((paddr == c_reg_aw_cnt) | (paddr == c_reg_b_cnt)));
    assign pslverr   = w_apb_acc & w_apb_err;

    assign w_req_lvl3 = 3'(w_req_level);
    assign w_rsp_lvl3 = 3'(w_rsp_level);
    assign w_status   = 32'({ovf_q, 1'b0, w_rsp_lvl3, 1'b0, w_req_lvl3});

    always_comb begin
        prdata = '0;
        if (w_apb_acc) begin
            case (paddr)
                c_reg_ctrl:   prdata = {31'd0, en_q};
                c_reg_status: prdata = w_status;
                c_reg_aw_cnt: prdata = aw_cnt_q;
                c_reg_b_cnt:  prdata = b_cnt_q;
                c_reg_limit:  prdata = 32'(limit_q);
                default:      prdata = '0;
            endcase
        end
    end

    // A new overflow in the same cycle as a W1C write wins.
    always_comb begin
        en_d     = en_q;
        limit_d  = limit_q;
        ovf_d    = ovf_q;
        aw_cnt_d = aw_cnt_q;
        b_cnt_d  = b_cnt_q;
        if (w_apb_wr & ~w_apb_err) begin
            case (paddr)
                c_reg_ctrl:   en_d    = pwdata[0];
                c_reg_status: if (pwdata[8]) ovf_d = 1'b0;
                c_reg_limit:  limit_d = ADDR_W'(pwdata);
                default:      en_d    = en_q;
            endcase
        end
        if (w_ovf_set) ovf_d    = 1'b1;
        if (w_a_hs)    aw_cnt_d = aw_cnt_q + 32'd1;
        if (w_b_hs)    b_cnt_d  = b_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b1;
            limit_q  <= '1;
            ovf_q    <= 1'b0;
            aw_cnt_q <= '0;
            b_cnt_q  <= '0;
        end else begin
            en_q     <= en_d;
            limit_q  <= limit_d;
            ovf_q    <= ovf_d;
            aw_cnt_q <= aw_cnt_d;
            b_cnt_q  <= b_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sal_axi_aw_b_apb_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sal_axi_aw_b_apb_unit
//  Purpose  : Self-checking bench with a queue-based reference model.
//  Revision : 1.0
// ============================================================================
module tb_sal_axi_aw_b_apb_unit;

    localparam int REQ_DEPTH = 4;
    localparam int RSP_DEPTH = 4;

    logic        clk, rst_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        avalid, aready;
    logic [3:0]  aid;
    logic [31:0] aaddr;
    logic [7:0]  alen;
    logic [2:0]  asize;
    logic [1:0]  aburst;
    logic        req_valid, req_ready;
    logic [3:0]  req_id;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        done_valid;
    logic [3:0]  done_id;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    sal_axi_aw_b_apb_unit #(
        .ID_W(4), .ADDR_W(32), .REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .avalid(avalid), .aready(aready), .aid(aid), .aaddr(aaddr),
        .alen(alen), .asize(asize), .aburst(aburst),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_addr(req_addr), .req_len(req_len),
        .done_valid(done_valid), .done_id(done_id),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } req_m_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } rsp_m_t;

    req_m_t      req_q[$];
    rsp_m_t      rsp_q[$];
    logic        m_en;
    logic [31:0] m_limit;
    logic        m_ovf;
    logic [31:0] m_awcnt, m_bcnt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        req_q.delete();
        rsp_q.delete();
        m_en = 1'b1; m_limit = 32'hFFFF_FFFF; m_ovf = 1'b0;
        m_awcnt = '0; m_bcnt = '0;
    endtask

    function automatic logic [31:0] model_reg(input logic [11:0] a);
        case (a)
            12'h000: return {31'd0, m_en};
            12'h004: return {23'd0, m_ovf, 1'b0, 3'(rsp_q.size()), 1'b0, 3'(req_q.size())};
            12'h008: return m_awcnt;
            12'h00C: return m_bcnt;
            12'h010: return m_limit;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_err(input logic [11:0] a, input logic wr);
        logic mapped;
        mapped = (a == 12'h000) || (a == 12'h004) || (a == 12'h008) ||
                 (a == 12'h00C) || (a == 12'h010);
        return !mapped || (wr && (a == 12'h008 || a == 12'h00C));
    endfunction

    // One clock with the currently driven AXI inputs; entered/left at posedge+1.
    task automatic run_cycle();
        logic inr, exp_ar, ahs, rhs, bhs;
        @(negedge clk);
        inr    = (aaddr <= m_limit);
        exp_ar = m_en && (req_q.size() < REQ_DEPTH) && (rsp_q.size() < RSP_DEPTH)
                 && !(done_valid && !inr);
        check_eq("aready", 64'(aready), 64'(exp_ar));
        check_eq("req_valid", 64'(req_valid), 64'(req_q.size() != 0));
        if (req_q.size() != 0) begin
            check_eq("req_id", 64'(req_id), 64'(req_q[0].id));
            check_eq("req_addr", 64'(req_addr), 64'(req_q[0].addr));
            check_eq("req_len", 64'(req_len), 64'(req_q[0].len));
        end
        check_eq("bvalid", 64'(bvalid), 64'(rsp_q.size() != 0));
        if (rsp_q.size() != 0) begin
            check_eq("bid", 64'(bid), 64'(rsp_q[0].id));
            check_eq("bresp", 64'(bresp), 64'(rsp_q[0].resp));
        end
        ahs = avalid && exp_ar;
        rhs = req_ready && (req_q.size() != 0);
        bhs = bready && (rsp_q.size() != 0);
        if (rhs) void'(req_q.pop_front());
        if (bhs) begin void'(rsp_q.pop_front()); m_bcnt++; end
        if (ahs) begin
            m_awcnt++;
            if (inr) req_q.push_back('{aid, aaddr, alen});
        end
        if (done_valid) begin
            if (rsp_q.size() < RSP_DEPTH) rsp_q.push_back('{done_id, 2'b00});
            else m_ovf = 1'b1;
        end else if (ahs && !inr) begin
            rsp_q.push_back('{aid, 2'b10});
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_cycle(input logic av, input logic [3:0] id, input logic [31:0] ad,
                             input logic [7:0] ln, input logic rr, input logic dv,
                             input logic [3:0] did, input logic br);
        avalid = av; aid = id; aaddr = ad; alen = ln;
        asize = 3'($urandom); aburst = 2'($urandom);
        req_ready = rr; done_valid = dv; done_id = did; bready = br;
        run_cycle();
    endtask

    task automatic axi_idle();
        avalid = 1'b0; req_ready = 1'b0; done_valid = 1'b0; bready = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a);
        axi_idle();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check_eq($sformatf("rd_%0h", a), 64'(prdata), 64'(model_reg(a)));
        check_eq($sformatf("rderr_%0h", a), 64'(pslverr), 64'(model_err(a, 1'b0)));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        logic err;
        axi_idle();
        err = model_err(a, 1'b1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check_eq($sformatf("wrerr_%0h", a), 64'(pslverr), 64'(err));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (!err) begin
            if (a == 12'h000) m_en = d[0];
            if (a == 12'h004 && d[8]) m_ovf = 1'b0;
            if (a == 12'h010) m_limit = d;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h000; pwdata = '0;
        avalid = 1'b1; aid = '0; aaddr = '0; alen = '0; asize = '0; aburst = '0;
        req_ready = 1'b0; done_valid = 1'b1; done_id = 4'd1; bready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_aready", 64'(aready), 64'd0);
        check_eq("rst_req_valid", 64'(req_valid), 64'd0);
        check_eq("rst_bvalid", 64'(bvalid), 64'd0);
        check_eq("rst_prdata", 64'(prdata), 64'd0);
        check_eq("rst_pslverr", 64'(pslverr), 64'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; axi_idle();
        rst_n = 1'b1;

        for (int a = 0; a <= 16; a += 4) apb_rd(12'(a));

        // In-order forwarding
        axi_cycle(1, 4'd0, 32'h0, 8'd0, 0, 0, 4'd0, 0);
        axi_cycle(1, 4'd0, 32'h4, 8'd0, 0, 0, 4'd0, 0);
        axi_cycle(0, 4'd0, 32'h0, 8'd0, 1, 0, 4'd0, 0);
        axi_cycle(0, 4'd0, 32'h0, 8'd0, 1, 0, 4'd0, 0);
        apb_rd(12'h008);
        check_eq("aw_cnt_two", 64'(m_awcnt), 64'd2);

        // Completion response
        axi_cycle(0, 4'd0, 32'h0, 8'd0, 0, 1, 4'd3, 1);
        axi_cycle(0, 4'd0, 32'h0, 8'd0, 0, 0, 4'd0, 1);
        apb_rd(12'h00C);

        // Address limit, including the exact boundary
        apb_wr(12'h010, 32'h0000_00FF);
        axi_cycle(1, 4'd5, 32'h100, 8'd2, 0, 0, 4'd0, 0);
        axi_cycle(0, 4'd0, 32'h0, 8'd0, 0, 0, 4'd0, 0);
        axi_cycle(1, 4'd6, 32'hFF, 8'd1, 0, 0, 4'd0, 1);
        axi_cycle(0, 4'd0, 32'h0, 8'd0, 1, 0, 4'd0, 0);
        // Out-of-range request colliding with a completion is held off
        axi_cycle(1, 4'd7, 32'h200, 8'd0, 0, 1, 4'd8, 0);
        axi_cycle(0, 4'd0, 32'h0, 8'd0, 0, 0, 4'd0, 1);
        apb_wr(12'h010, 32'hFFFF_FFFF);

        // Request FIFO fills at four
        for (int i = 0; i < 5; i++)
            axi_cycle(1, 4'(i), 32'(i * 16), 8'(i), 0, 0, 4'd0, 0);
        apb_rd(12'h004);
        for (int i = 0; i < 4; i++) axi_cycle(0, 4'd0, 32'h0, 8'd0, 1, 0, 4'd0, 0);

        // Disable: nothing new accepted, queue drains
        axi_cycle(1, 4'd9, 32'h40, 8'd3, 0, 0, 4'd0, 0);
        apb_wr(12'h000, 32'h0);
        axi_cycle(1, 4'd10, 32'h44, 8'd0, 1, 0, 4'd0, 0);
        axi_cycle(1, 4'd10, 32'h44, 8'd0, 1, 0, 4'd0, 0);
        apb_rd(12'h020);
        apb_wr(12'h008, 32'h1234);
        apb_wr(12'h00C, 32'h1234);
        apb_wr(12'h000, 32'h1);

        // Response overflow and W1C
        for (int i = 0; i < 5; i++) axi_cycle(0, 4'd0, 32'h0, 8'd0, 0, 1, 4'(i), 0);
        apb_rd(12'h004);
        apb_wr(12'h004, 32'h0000_0100);
        apb_rd(12'h004);
        // Completion at full with a simultaneous B handshake is kept
        axi_cycle(0, 4'd0, 32'h0, 8'd0, 0, 1, 4'd12, 1);
        apb_rd(12'h004);
        for (int i = 0; i < 4; i++) axi_cycle(0, 4'd0, 32'h0, 8'd0, 0, 0, 4'd0, 1);

        // Randomized traffic
        apb_wr(12'h010, 32'h8000_0000);
        for (int i = 0; i < 1500; i++) begin
            axi_cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 8'($urandom),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                      4'($urandom), 1'($urandom_range(0, 2) != 0));
            if (i % 100 == 99) begin
                apb_rd(12'h004);
                apb_rd(12'h008);
                apb_rd(12'h00C);
                if (m_ovf) apb_wr(12'h004, 32'h0000_0100);
            end
        end

        // Mid-operation reset drops queued entries
        for (int i = 0; i < 3; i++) axi_cycle(1, 4'(i), 32'h10, 8'd0, 0, 1, 4'(i), 0);
        avalid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_req_valid", 64'(req_valid), 64'd0);
        check_eq("mid_rst_bvalid", 64'(bvalid), 64'd0);
        check_eq("mid_rst_aready", 64'(aready), 64'd0);
        @(posedge clk); #1;
        axi_idle();
        rst_n = 1'b1;
        model_reset();
        for (int a = 0; a <= 16; a += 4) apb_rd(12'(a));
        for (int i = 0; i < 50; i++)
            axi_cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 8'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      4'($urandom), 1'($urandom_range(0, 1)));
        apb_rd(12'h008);
        apb_rd(12'h00C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
